// File: rtl/partial_sum_iter_acc_pkg.sv
// Shared types and lane geometry for the partial-sum iteration accumulator.
`include "Para.v"

package partial_sum_iter_acc_pkg;

    localparam int LANES  = `PICTURE_NUM;
    localparam int LANE_W = `WIDTH_DATA_OUT * 2;
    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_FLUSH
    } state_t;

    // Role of a beat within the channel-in iteration sequence.
    typedef struct packed {
        logic first;  // pass 0: buffer contents are stale and ignored
        logic last;   // pass N-1: result leaves on data_out, no write-back
    } pass_t;

endpackage

// File: rtl/Para.v
// Shared lane geometry for the convolution datapath.
`ifndef PARA_V
`define PARA_V
`define PICTURE_NUM    8
`define WIDTH_DATA_OUT 16
`endif

// File: rtl/psum_ram.sv
// Simple dual-port partial-sum buffer with a one-cycle registered read.
module psum_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 256
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    // NOTE: the storage array has no reset; every entry is written on pass 0 before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-cycle write to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/partial_sum_iter_acc.sv
// Accumulates per-lane partial sums over cfg_iter_num channel-in passes of
// cfg_pix_num pixels and emits the final sums on the last pass.
module partial_sum_iter_acc
    import partial_sum_iter_acc_pkg::*;
#(
    parameter int PIX_MAX = 256,
    parameter int PIX_AW  = 8,
    parameter int ITER_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PIX_AW:0]   cfg_pix_num,
    input  logic [ITER_W-1:0] cfg_iter_num,
    input  logic              data_in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [PIX_AW:0]   pix_num_q;
    logic [ITER_W-1:0] iter_num_q;
    logic [PIX_AW-1:0] pix_cnt;
    logic [ITER_W-1:0] iter_cnt;
    logic [PIX_AW:0]   pix_cnt_p1;
    logic [ITER_W-1:0] iter_cnt_p1;
    logic              beat;
    logic              pix_wrap;
    pass_t             pass_now;

    // Stage 1: beat waiting for its buffer read to return.
    logic              s1_valid;
    pass_t             s1_pass;
    logic [PIX_AW-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;

    // Forwarded write for a read that collided with it in the same cycle.
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    logic              wr_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] sum;

    assign beat        = (state == ST_ACC) && data_in_valid;
    assign pix_cnt_p1  = {1'b0, pix_cnt} + {{PIX_AW{1'b0}}, 1'b1};
    assign iter_cnt_p1 = iter_cnt + {{(ITER_W-1){1'b0}}, 1'b1};
    assign pix_wrap    = (pix_cnt_p1 == pix_num_q);
    assign pass_now    = '{first: (iter_cnt == '0), last: (iter_cnt_p1 == iter_num_q)};
    assign wr_en       = s1_valid && !s1_pass.last;

    // Control FSM with registered busy/done.
    // NOTE: all state here is updated with non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pix_num_q  <= '0;
            iter_num_q <= '0;
            pix_cnt    <= '0;
            iter_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pix_num_q  <= (cfg_pix_num == '0) ? {{PIX_AW{1'b0}}, 1'b1} : cfg_pix_num;
                        iter_num_q <= (cfg_iter_num == '0) ? {{(ITER_W-1){1'b0}}, 1'b1} : cfg_iter_num;
                        pix_cnt    <= '0;
                        iter_cnt   <= '0;
                        busy       <= 1'b1;
                        state      <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (data_in_valid) begin
                        if (pix_wrap) begin
                            pix_cnt <= '0;
                            if (pass_now.last) begin
                                state <= ST_FLUSH;
                            end else begin
                                iter_cnt <= iter_cnt_p1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt_p1[PIX_AW-1:0];
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!s1_valid) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage-1 valid and the same-cycle read/write collision flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            byp_hit  <= 1'b0;
        end else begin
            s1_valid <= beat;
            byp_hit  <= beat && wr_en && (s1_addr == pix_cnt);
        end
    end

    // Stage-1 payload and forwarded write data; qualified by the flags above.
    always_ff @(posedge clk) begin
        s1_pass  <= pass_now;
        s1_addr  <= pix_cnt;
        s1_data  <= data_in;
        byp_data <= sum;
    end

    psum_ram #(
        .DEPTH (PIX_MAX),
        .AW    (PIX_AW),
        .DW    (DATA_W)
    ) u_psum_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (s1_addr),
        .wr_data (sum),
        .rd_en   (beat),
        .rd_addr (pix_cnt),
        .rd_data (rd_data)
    );

    // Accumulator operand: zero on pass 0, forwarded write on a collision, else RAM.
    // NOTE: operand is assigned on every path so no latch is inferred.
    always_comb begin
        operand = rd_data;
        if (s1_pass.first) begin
            operand = '0;
        end else if (byp_hit) begin
            operand = byp_data;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane_add
        assign sum[l*LANE_W +: LANE_W] = operand[l*LANE_W +: LANE_W] + s1_data[l*LANE_W +: LANE_W];
    end

    // Output register; data_out holds between final-pass beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            data_out_valid <= s1_valid && s1_pass.last;
            if (s1_valid && s1_pass.last) begin
                data_out <= sum;
            end
        end
    end

endmodule

// File: doc/partial_sum_iter_acc.md
PARTIAL_SUM_ITER_ACC -- requirements
Module: partial_sum_iter_acc

Interface
REQ-001 Parameter PIX_MAX, 256: maximum output pixels per pass (partial-sum buffer depth).
REQ-002 Parameter PIX_AW, 8: pixel address width, clog2(PIX_MAX).
REQ-003 Parameter ITER_W, 8: width of the channel-in iteration count.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: single-cycle pulse that latches configuration and begins a tile.
REQ-008 Port cfg_pix_num, input, PIX_AW+1: pixels per pass, 1..PIX_MAX.
REQ-009 Port cfg_iter_num, input, ITER_W: channel-in passes per tile, 1..2^ITER_W-1.
REQ-010 Port data_in_valid, input, 1: data_in beat qualifier.
REQ-011 Port data_in, input, `PICTURE_NUM*`WIDTH_DATA_OUT*2: per-lane channel-reduced partial sums from the upstream adder tree.
REQ-012 Port data_out_valid, output, 1: final-sum beat qualifier.
REQ-013 Port data_out, output, `PICTURE_NUM*`WIDTH_DATA_OUT*2: accumulated sums, same lane packing as data_in.
REQ-014 Port busy, output, 1: high from the cycle after start until done.
REQ-015 Port done, output, 1: single-cycle pulse one cycle after the last data_out_valid beat.

Function
REQ-016 Lanes: `PICTURE_NUM independent signed lanes of W=`WIDTH_DATA_OUT*2 bits; lane i occupies bits [(i+1)*W-1 : i*W].
REQ-017 Lane addition SHALL be two's-complement, modulo 2^W (wrap, no saturation).
REQ-018 FSM states: IDLE, ACC, FLUSH.
- IDLE -> ACC on start: latch cfg_pix_num and cfg_iter_num; clear pix_cnt and iter_cnt.
- ACC -> FLUSH after the last beat of the last pass.
- FLUSH -> IDLE once the output pipeline drains; done asserts on that transition.
REQ-019 Configuration value 0 in either cfg field SHALL be treated as 1.
REQ-020 In ACC, each data_in_valid beat addresses buffer entry pix_cnt.
- pix_cnt wraps from cfg_pix_num-1 to 0, and iter_cnt increments on that wrap.
- Gaps in data_in_valid are allowed and SHALL NOT affect results.
REQ-021 Pass 0 SHALL write data_in to the buffer, ignoring stale contents.
REQ-022 Passes 1..N-2 SHALL write buffer[pix] + data_in back to the buffer.
REQ-023 Pass N-1 SHALL emit buffer[pix] + data_in on data_out, with data_out_valid, and SHALL NOT need to write back.
REQ-024 With N=1, data_out SHALL equal data_in.
REQ-025 Latency: data_out_valid SHALL assert exactly 2 cycles after the accepting data_in_valid beat; output order equals input order.
REQ-026 Read-after-write hazard: when cfg_pix_num is 1 or 2 and beats are back-to-back, the adder operand SHALL come from a bypass of the pending write, never from stale RAM.
REQ-027 No backpressure: the block SHALL accept one beat per cycle indefinitely.
REQ-028 data_in_valid in IDLE or FLUSH SHALL be ignored.
REQ-029 start while busy SHALL be ignored.
REQ-030 data_out SHALL hold its last value when data_out_valid is low.

Reset
REQ-031 rst SHALL have priority over all inputs, including start in the same cycle.
REQ-032 On rst: FSM to IDLE; counters, busy, done and data_out_valid to 0; data_out to 0.
REQ-033 rst mid-tile SHALL abort the tile with no further data_out_valid; buffer contents need not be cleared.

Structure
REQ-034 `PICTURE_NUM and `WIDTH_DATA_OUT SHALL come from the shared Para.v include; no local redefinition.
REQ-035 A single sub-module psum_ram SHALL hold the buffer: simple dual-port, PIX_MAX x `PICTURE_NUM*W, 1-cycle registered read, write-first not relied upon.
REQ-036 Lane adders SHALL be inline generate logic, one W-bit adder per lane.

Verification (`PICTURE_NUM=8, `WIDTH_DATA_OUT=16, W=32)
REQ-037 Pixels 4, iters 3, lane k of pixel p = p+k each pass, continuous valid -> 4 outputs, lane k = 3*(p+k), first output 2 cycles after beat 8, then done.
REQ-038 Pixels 1, iters 5, back-to-back beats of lane values 1,2,3,4,5 -> single output with every lane 15 (bypass exercised).
REQ-039 Lane value 32'h7FFFFFFF twice, iters 2 -> lane 32'hFFFFFFFE (wrap); lane -5 plus 3 -> 32'hFFFFFFFE.
REQ-040 Iters 1, pixels 256, random data with random valid gaps -> data_out equals data_in with 2-cycle latency; done after beat 256.
REQ-041 rst asserted during pass 1 of a pixels-4/iters-3 tile, then a new tile started -> no output from the aborted tile; new tile correct, unaffected by stale buffer contents.
REQ-042 start pulsed while busy, plus data_in_valid in IDLE -> both ignored; outputs unchanged.
